nf_mem_arb: RTL and testbench
=============================

NF_MEM_ARB -- requirements
Module: nf_mem_arb

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: maximum consecutive data-port grants while an instruction request waits; legal range 1..7.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port addr_i  in  32  instruction-port address.
REQ-005 SHALL have port wd_i  in  32  instruction-port write data.
REQ-006 SHALL have port we_i  in  1  instruction-port write enable.
REQ-007 SHALL have port req_i  in  1  instruction-port request.
REQ-008 SHALL have port rd_i  out  32  instruction-port read data.
REQ-009 SHALL have port req_ack_i  out  1  instruction-port completion pulse.
REQ-010 SHALL have ports addr_dm / wd_dm / we_dm / req_dm (in; 32/32/1/1) and rd_dm / req_ack_dm (out; 32/1): the data port, with the same meanings as REQ-004..REQ-009.
REQ-011 SHALL have ports addr_m / wd_m / we_m / req_m (out; 32/32/1/1): the shared memory request.
REQ-012 SHALL have port rd_m  in  32  memory read data, valid while req_ack_m=1.
REQ-013 SHALL have port req_ack_m  in  1  memory completion, 1 cycle, variable latency.

Function
REQ-014 SHALL implement FSM states IDLE, GNT_I, GNT_D and RESP.
REQ-015 SHALL, in IDLE, stay in IDLE when req_i=0 and req_dm=0.
REQ-016 SHALL, in IDLE, otherwise select the winner as follows:
  - req_i=1 and starve_cnt==STARVE_MAX: instruction port -> GNT_I.
  - otherwise, req_dm=1: data port -> GNT_D.
  - otherwise: instruction port -> GNT_I.
REQ-017 SHALL, on the IDLE->grant transition, latch the winner's addr/wd/we; addr_m/wd_m/we_m SHALL drive the latched values, so requester changes after grant have no effect.
REQ-018 SHALL assert req_m=1 exactly while in GNT_I or GNT_D, and 0 in all other states.
REQ-019 SHALL hold we_m=0 outside GNT_I/GNT_D.
REQ-020 SHALL, in GNT_x, stay in GNT_x while req_ack_m=0 (no timeout).
REQ-021 SHALL, in GNT_x with req_ack_m=1:
  - capture rd_m into rd_x (rd_i or rd_dm);
  - transition to RESP.
REQ-022 SHALL, in RESP, pulse req_ack_x=1 for exactly one cycle for the granted port only, with rd_x valid; RESP -> IDLE unconditionally.
REQ-023 SHALL ignore all requests while in RESP.
REQ-024 SHALL treat a req still high in the cycle after RESP (now IDLE) as a new request; requesters SHALL drop req in the cycle req_ack_x is seen.
REQ-025 SHALL hold rd_i and rd_dm until the next completion for the same port; the other port's completion SHALL NOT alter them.
REQ-026 SHALL give a minimum latency of 2 cycles from req sampled in IDLE to req_ack_x, with req_ack_m in the first GNT cycle.
REQ-027 SHALL give a maximum throughput of one transaction per 3 cycles.
REQ-028 SHALL update starve_cnt (3-bit) at each grant:
  - D grant with req_i=1: +1, saturating at STARVE_MAX.
  - D grant with req_i=0: cleared to 0.
  - I grant: cleared to 0.
REQ-029 SHALL ignore req_ack_m=1 while in IDLE or RESP: no state change, no ack, rd unchanged.
REQ-030 SHALL complete a granted transaction even if the requester deasserts req mid-grant (req_ack_x still pulses).
REQ-031 SHALL set req_ack_i and req_ack_dm to 1 in the same cycle never.

Reset
REQ-032 SHALL, on reset=1 at a clock edge, force the following:
  - state=IDLE, starve_cnt=0;
  - req_m=0, we_m=0, addr_m=0, wd_m=0;
  - rd_i=0, rd_dm=0;
  - req_ack_i=0, req_ack_dm=0.
REQ-033 SHALL, on reset mid-transaction, abandon the transaction; a later req_ack_m SHALL be ignored per REQ-029.
REQ-034 SHALL give reset priority over all other inputs.

Verification
REQ-035 SHALL cover the single instruction read: req_i=1, addr_i=0x100, memory acks in the first GNT cycle with rd_m=0xDEADBEEF -> req_m=1 at cycle+1, req_ack_i=1 at cycle+2 with rd_i=0xDEADBEEF.
REQ-036 SHALL cover the simultaneous request: req_i=req_dm=1 with starve_cnt=0 -> data port granted first, req_ack_dm before req_ack_i, each within its own 3-cycle window.
REQ-037 SHALL cover starvation: req_i held high with req_dm re-requested continuously, STARVE_MAX=4 -> exactly 4 data grants, then an instruction grant, then starve_cnt=0.
REQ-038 SHALL cover the data write with a 5-cycle memory latency: req_dm=1, we_dm=1, addr_dm=0x2000, wd_dm=0x55 -> addr_m=0x2000/wd_m=0x55/we_m=1 stable for 5 cycles despite input changes, then req_ack_dm pulses once.
REQ-039 SHALL cover reset mid-GNT_D followed by a stray req_ack_m=1 -> req_m=0 after reset, no req_ack_dm, rd_dm=0, FSM in IDLE.
REQ-040 SHALL cover req_ack_m=1 while in IDLE -> no outputs change.

Source files
------------

// File: rtl/nf_mem_arb.sv
// nf_mem_arb: two-port (instruction / data) arbiter in front of a single
// memory port. One transaction at a time: IDLE -> GNT_x -> RESP -> IDLE.
// The data port normally wins ties; a saturating starvation counter
// forces an instruction grant after STARVE_MAX back-to-back data grants
// taken while the instruction port was waiting.
module nf_mem_arb #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    // instruction port
    input  logic [31:0] addr_i,
    input  logic [31:0] wd_i,
    input  logic        we_i,
    input  logic        req_i,
    output logic [31:0] rd_i,
    output logic        req_ack_i,
    // data port
    input  logic [31:0] addr_dm,
    input  logic [31:0] wd_dm,
    input  logic        we_dm,
    input  logic        req_dm,
    output logic [31:0] rd_dm,
    output logic        req_ack_dm,
    // shared memory port
    output logic [31:0] addr_m,
    output logic [31:0] wd_m,
    output logic        we_m,
    output logic        req_m,
    input  logic [31:0] rd_m,
    input  logic        req_ack_m
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GNT_I = 2'd1;
    localparam logic [1:0] S_GNT_D = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [2:0] LP_STARVE_MAX = 3'(STARVE_MAX);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [2:0]  r_starve_cnt;
    logic        r_sel_d;      // 1 when the current/last grant went to the data port
    logic [31:0] r_addr;
    logic [31:0] r_wd;
    logic        r_we;
    logic [31:0] r_rd_i;
    logic [31:0] r_rd_dm;
    logic        w_grant;
    logic        w_pick_i;

    // Arbitration decision, only meaningful while IDLE
    always_comb begin
        w_grant  = (r_state == S_IDLE) && (req_i || req_dm);
        w_pick_i = req_i && ((r_starve_cnt == LP_STARVE_MAX) || !req_dm);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    // Next-state logic; RESP ignores every request and returns to IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant)
                    w_next_state = w_pick_i ? S_GNT_I : S_GNT_D;
            end
            S_GNT_I, S_GNT_D: begin
                if (req_ack_m)
                    w_next_state = S_RESP;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Grant latch, starvation counter and read-data capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= 3'd0;
            r_sel_d      <= 1'b0;
            r_addr       <= 32'd0;
            r_wd         <= 32'd0;
            r_we         <= 1'b0;
            r_rd_i       <= 32'd0;
            r_rd_dm      <= 32'd0;
        end else begin
            if (w_grant) begin
                r_sel_d <= !w_pick_i;
                r_addr  <= w_pick_i ? addr_i : addr_dm;
                r_wd    <= w_pick_i ? wd_i   : wd_dm;
                r_we    <= w_pick_i ? we_i   : we_dm;
                if (w_pick_i || !req_i)
                    r_starve_cnt <= 3'd0;
                else if (r_starve_cnt != LP_STARVE_MAX)
                    r_starve_cnt <= r_starve_cnt + 3'd1;
            end
            if ((r_state == S_GNT_I) && req_ack_m)
                r_rd_i <= rd_m;
            if ((r_state == S_GNT_D) && req_ack_m)
                r_rd_dm <= rd_m;
        end
    end

    // Outputs decoded from state; write enable only ever visible during a grant
    always_comb begin
        req_m      = (r_state == S_GNT_I) || (r_state == S_GNT_D);
        we_m       = req_m && r_we;
        req_ack_i  = (r_state == S_RESP) && !r_sel_d;
        req_ack_dm = (r_state == S_RESP) &&  r_sel_d;
        addr_m     = r_addr;
        wd_m       = r_wd;
        rd_i       = r_rd_i;
        rd_dm      = r_rd_dm;
    end

endmodule

// File: tb/tb_nf_mem_arb.sv
// Directed testbench for nf_mem_arb with hand-computed expectations.
module tb_nf_mem_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr_i, wd_i, rd_i;
    logic        we_i, req_i, req_ack_i;
    logic [31:0] addr_dm, wd_dm, rd_dm;
    logic        we_dm, req_dm, req_ack_dm;
    logic [31:0] addr_m, wd_m, rd_m;
    logic        we_m, req_m, req_ack_m;

    int n_checks = 0;
    int n_errors = 0;

    nf_mem_arb #(.STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .addr_i(addr_i), .wd_i(wd_i), .we_i(we_i), .req_i(req_i),
        .rd_i(rd_i), .req_ack_i(req_ack_i),
        .addr_dm(addr_dm), .wd_dm(wd_dm), .we_dm(we_dm), .req_dm(req_dm),
        .rd_dm(rd_dm), .req_ack_dm(req_ack_dm),
        .addr_m(addr_m), .wd_m(wd_m), .we_m(we_m), .req_m(req_m),
        .rd_m(rd_m), .req_ack_m(req_ack_m)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        addr_i = 0; wd_i = 0; we_i = 0; req_i = 0;
        addr_dm = 0; wd_dm = 0; we_dm = 0; req_dm = 0;
        rd_m = 0; req_ack_m = 0;
        tick(); tick();
        reset = 1'b0;

        // reset state
        chk("rst_req_m", {31'd0, req_m}, 32'd0);
        chk("rst_we_m", {31'd0, we_m}, 32'd0);
        chk("rst_addr_m", addr_m, 32'd0);
        chk("rst_wd_m", wd_m, 32'd0);
        chk("rst_rd_i", rd_i, 32'd0);
        chk("rst_rd_dm", rd_dm, 32'd0);
        chk("rst_acks", {30'd0, req_ack_i, req_ack_dm}, 32'd0);

        // single instruction read, memory acks in the first grant cycle
        req_i = 1; addr_i = 32'h100; we_i = 0;
        tick();
        chk("ird_req_m", {31'd0, req_m}, 32'd1);
        chk("ird_addr_m", addr_m, 32'h100);
        chk("ird_we_m", {31'd0, we_m}, 32'd0);
        req_ack_m = 1; rd_m = 32'hDEADBEEF;
        tick();
        req_ack_m = 0;
        chk("ird_ack_i", {31'd0, req_ack_i}, 32'd1);
        chk("ird_ack_dm", {31'd0, req_ack_dm}, 32'd0);
        chk("ird_rd_i", rd_i, 32'hDEADBEEF);
        chk("ird_req_m_resp", {31'd0, req_m}, 32'd0);
        req_i = 0;
        tick();
        chk("ird_ack_i_done", {31'd0, req_ack_i}, 32'd0);
        chk("ird_rd_i_hold", rd_i, 32'hDEADBEEF);

        // simultaneous request: data first, then instruction
        req_i = 1; addr_i = 32'h10; req_dm = 1; addr_dm = 32'h20;
        tick();
        chk("sim_gnt_d_addr", addr_m, 32'h20);
        chk("sim_gnt_d_req", {31'd0, req_m}, 32'd1);
        req_ack_m = 1; rd_m = 32'h1111;
        tick();
        req_ack_m = 0;
        chk("sim_ack_dm", {30'd0, req_ack_i, req_ack_dm}, 32'd1);
        chk("sim_rd_dm", rd_dm, 32'h1111);
        chk("sim_rd_i_kept", rd_i, 32'hDEADBEEF);
        req_dm = 0;
        tick();
        chk("sim_idle", {31'd0, req_m}, 32'd0);
        tick();
        chk("sim_gnt_i_addr", addr_m, 32'h10);
        chk("sim_gnt_i_req", {31'd0, req_m}, 32'd1);
        req_ack_m = 1; rd_m = 32'h2222;
        tick();
        req_ack_m = 0;
        chk("sim_ack_i", {30'd0, req_ack_i, req_ack_dm}, 32'd2);
        chk("sim_rd_i", rd_i, 32'h2222);
        chk("sim_rd_dm_kept", rd_dm, 32'h1111);
        req_i = 0;
        tick();

        // starvation: four data grants, then one instruction grant, then data again
        req_i = 1; addr_i = 32'hA0; req_dm = 1; addr_dm = 32'hB0;
        for (int k = 0; k < 6; k++) begin
            logic [31:0] exp_addr;
            logic [31:0] exp_acks;
            exp_addr = (k == 4) ? 32'hA0 : 32'hB0;
            exp_acks = (k == 4) ? 32'd2 : 32'd1;
            tick();
            chk($sformatf("stv_addr%0d", k), addr_m, exp_addr);
            req_ack_m = 1; rd_m = 32'h3000 + k;
            tick();
            req_ack_m = 0;
            chk($sformatf("stv_ack%0d", k), {30'd0, req_ack_i, req_ack_dm}, exp_acks);
            if (k == 5) begin
                req_i = 0; req_dm = 0;
            end
            tick();
        end
        chk("stv_rd_i", rd_i, 32'h3004);
        chk("stv_rd_dm", rd_dm, 32'h3005);

        // data write with 5-cycle memory latency, inputs changed after grant
        req_dm = 1; we_dm = 1; addr_dm = 32'h2000; wd_dm = 32'h55;
        tick();
        req_dm = 0; we_dm = 0; addr_dm = 32'hFFFF; wd_dm = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("wr_addr%0d", i), addr_m, 32'h2000);
            chk($sformatf("wr_wd%0d", i), wd_m, 32'h55);
            chk($sformatf("wr_we_req%0d", i), {30'd0, we_m, req_m}, 32'd3);
            chk($sformatf("wr_noack%0d", i), {31'd0, req_ack_dm}, 32'd0);
            if (i == 4) begin
                req_ack_m = 1; rd_m = 32'h77;
            end
            tick();
        end
        req_ack_m = 0;
        chk("wr_ack_dm", {30'd0, req_ack_i, req_ack_dm}, 32'd1);
        chk("wr_we_resp", {30'd0, we_m, req_m}, 32'd0);
        chk("wr_rd_dm", rd_dm, 32'h77);
        tick();
        chk("wr_ack_once", {30'd0, req_ack_i, req_ack_dm}, 32'd0);
        chk("wr_we_idle", {31'd0, we_m}, 32'd0);

        // reset mid-GNT_D, then a stray memory ack
        req_dm = 1; addr_dm = 32'h3000; we_dm = 0;
        tick();
        chk("rmid_req_m", {31'd0, req_m}, 32'd1);
        reset = 1; req_dm = 0;
        tick();
        reset = 0;
        chk("rmid_req_m_off", {31'd0, req_m}, 32'd0);
        chk("rmid_rd_dm", rd_dm, 32'd0);
        chk("rmid_addr_m", addr_m, 32'd0);
        req_ack_m = 1; rd_m = 32'h99;
        tick();
        req_ack_m = 0;
        chk("rmid_stray_acks", {30'd0, req_ack_i, req_ack_dm}, 32'd0);
        chk("rmid_stray_rd_dm", rd_dm, 32'd0);
        chk("rmid_stray_req_m", {31'd0, req_m}, 32'd0);

        // memory ack while IDLE changes nothing
        req_ack_m = 1; rd_m = 32'h1234;
        tick();
        req_ack_m = 0;
        chk("idle_ack_acks", {30'd0, req_ack_i, req_ack_dm}, 32'd0);
        chk("idle_ack_rd_i", rd_i, 32'd0);
        chk("idle_ack_rd_dm", rd_dm, 32'd0);
        chk("idle_ack_req_m", {31'd0, req_m}, 32'd0);
        chk("idle_ack_addr_m", addr_m, 32'd0);

        // arbiter still in IDLE: a fresh request is granted next cycle
        req_i = 1; addr_i = 32'h44;
        tick();
        req_i = 0;
        chk("post_gnt_req_m", {31'd0, req_m}, 32'd1);
        chk("post_gnt_addr", addr_m, 32'h44);
        req_ack_m = 1; rd_m = 32'h5A5A;
        tick();
        req_ack_m = 0;
        chk("post_ack_i", {30'd0, req_ack_i, req_ack_dm}, 32'd2);
        chk("post_rd_i", rd_i, 32'h5A5A);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
